// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, state encoding and instruction fields for the 8-bit RISC CPU
// Purpose: common definitions imported by cpu_control_fsm and alu8.
// Contents: data/instruction/register-address widths, opcode values,
//           FSM state enum, IR field bit positions, opcode class helpers.
package cpu_pkg;

   localparam int DATA_W  = 8;
   localparam int INSTR_W = 16;
   localparam int REG_AW  = 3;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_XOR = 4'h5;
   localparam logic [3:0] OP_LDI = 4'h6;
   localparam logic [3:0] OP_MOV = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_JMP = 4'h9;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_WRITEBACK = 3'd3,
      S_HALT      = 3'd4
   } state_t;

   localparam int OP_HI  = 15;
   localparam int OP_LO  = 12;
   localparam int RD_HI  = 11;
   localparam int RD_LO  = 9;
   localparam int RS1_HI = 8;
   localparam int RS1_LO = 6;
   localparam int RS2_HI = 5;
   localparam int RS2_LO = 3;
   localparam int IMM_HI = 7;
   localparam int IMM_LO = 0;

   // Opcodes that produce a register-file write (ADD..MOV).
   function automatic logic is_write_op(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_MOV);
   endfunction

   // Opcodes that update the zero flag (ADD..XOR only; LDI/MOV leave it alone).
   function automatic logic is_flag_op(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_XOR);
   endfunction

endpackage

// File: rtl/alu8.sv
// rtl/alu8.sv - combinational 8-bit ALU used in the EXECUTE stage
// Purpose: computes the result of ADD/SUB/AND/OR/XOR/LDI/MOV.
// Ports:
//   op     in  4  opcode (IR[15:12])
//   a      in  8  operand A (register rs1)
//   b      in  8  operand B (register rs2)
//   imm    in  8  immediate (IR[7:0])
//   result out 8  operation result, modulo 256
//   zero   out 1  result == 0
module alu8
   import cpu_pkg::*;
(
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] imm,
   output logic [DATA_W-1:0] result,
   output logic              zero
);

   always_comb begin
      result = '0;
      case (op)
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_LDI:  result = imm;
         OP_MOV:  result = a;
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/cpu_control_fsm.sv
// rtl/cpu_control_fsm.sv - multi-cycle fetch/decode/execute/writeback controller for the 8-bit RISC CPU
// Purpose: holds PC, IR and Z flag; fetches over a req/valid handshake and
//          drives the register file read/write ports.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   instr_req  out 1     waiting for an instruction (FETCH)
//   pc         out 8     fetch address
//   instr_valid in 1     instr_data valid (sampled only in FETCH)
//   instr_data in 16     instruction word
//   read_reg1/2 out 3    register file read addresses (IR[8:6], IR[5:3])
//   read_data1/2 in 8    register file read data
//   reg_write  out 1     register file write strobe (one cycle, WRITEBACK)
//   write_reg  out 3     destination register (IR[11:9])
//   write_data out 8     value written
//   zero_flag  out 1     Z flag
//   halted     out 1     HLT has executed
module cpu_control_fsm
   import cpu_pkg::*;
#(
   parameter logic [DATA_W-1:0] PC_RESET = 8'h00
)(
   input  logic                clk,
   input  logic                rst,
   output logic                instr_req,
   output logic [DATA_W-1:0]   pc,
   input  logic                instr_valid,
   input  logic [INSTR_W-1:0]  instr_data,
   output logic [REG_AW-1:0]   read_reg1,
   output logic [REG_AW-1:0]   read_reg2,
   input  logic [DATA_W-1:0]   read_data1,
   input  logic [DATA_W-1:0]   read_data2,
   output logic                reg_write,
   output logic [REG_AW-1:0]   write_reg,
   output logic [DATA_W-1:0]   write_data,
   output logic                zero_flag,
   output logic                halted
);

   state_t              state;
   state_t              state_next;
   logic [INSTR_W-1:0]  ir;
   logic [3:0]          opcode;
   logic [DATA_W-1:0]   alu_result;
   logic                alu_zero;
   logic                take_jump;

   assign opcode = ir[OP_HI:OP_LO];

   alu8 u_alu (
      .op     (opcode),
      .a      (read_data1),
      .b      (read_data2),
      .imm    (ir[IMM_HI:IMM_LO]),
      .result (alu_result),
      .zero   (alu_zero)
   );

   // JZ uses the flag as it stands before this instruction; JZ never updates Z.
   assign take_jump = (opcode == OP_JMP) || ((opcode == OP_JZ) && zero_flag);

   always_ff @(posedge clk) begin
      if (rst) state <= S_FETCH;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      instr_req  = 1'b0;
      reg_write  = 1'b0;
      halted     = 1'b0;
      case (state)
         S_FETCH: begin
            instr_req = 1'b1;
            if (instr_valid) state_next = S_DECODE;
         end
         S_DECODE: state_next = S_EXECUTE;
         S_EXECUTE: begin
            if (is_write_op(opcode))   state_next = S_WRITEBACK;
            else if (opcode == OP_HLT) state_next = S_HALT;
            else                       state_next = S_FETCH;
         end
         S_WRITEBACK: begin
            // Gated so a reset landing on the writeback cycle commits nothing.
            reg_write  = !rst;
            state_next = S_FETCH;
         end
         S_HALT: halted = 1'b1;
         default: state_next = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc         <= PC_RESET;
         ir         <= '0;
         zero_flag  <= 1'b0;
         read_reg1  <= '0;
         read_reg2  <= '0;
         write_reg  <= '0;
         write_data <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (instr_valid) begin
                  ir <= instr_data;
                  pc <= pc + 8'd1;
               end
            end
            S_DECODE: begin
               read_reg1 <= ir[RS1_HI:RS1_LO];
               read_reg2 <= ir[RS2_HI:RS2_LO];
            end
            S_EXECUTE: begin
               // write_data doubles as the result register, so it holds after the pulse.
               if (is_write_op(opcode)) begin
                  write_data <= alu_result;
                  write_reg  <= ir[RD_HI:RD_LO];
               end
               if (is_flag_op(opcode)) zero_flag <= alu_zero;
               if (take_jump)          pc <= ir[IMM_HI:IMM_LO];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb/tb_cpu_control_fsm.sv - scoreboard testbench for cpu_control_fsm
module tb_cpu_control_fsm;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_req;
   logic [7:0]  pc;
   logic        instr_valid;
   logic [15:0] instr_data;
   logic [2:0]  read_reg1;
   logic [2:0]  read_reg2;
   logic [7:0]  read_data1;
   logic [7:0]  read_data2;
   logic        reg_write;
   logic [2:0]  write_reg;
   logic [7:0]  write_data;
   logic        zero_flag;
   logic        halted;

   typedef struct {
      logic [2:0] wreg;
      logic [7:0] wdata;
      logic       z;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;

   cpu_control_fsm #(.PC_RESET(8'h00)) dut (
      .clk         (clk),
      .rst         (rst),
      .instr_req   (instr_req),
      .pc          (pc),
      .instr_valid (instr_valid),
      .instr_data  (instr_data),
      .read_reg1   (read_reg1),
      .read_reg2   (read_reg2),
      .read_data1  (read_data1),
      .read_data2  (read_data2),
      .reg_write   (reg_write),
      .write_reg   (write_reg),
      .write_data  (write_data),
      .zero_flag   (zero_flag),
      .halted      (halted)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: every write pulse must match the oldest expected write.
   always @(negedge clk) begin
      if (reg_write === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_write: reg %0d data %0h at cycle %0d", write_reg, write_data, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("write_reg", {29'd0, write_reg}, {29'd0, e.wreg});
            chk("write_data", {24'd0, write_data}, {24'd0, e.wdata});
            chk("wb_zero_flag", {31'd0, zero_flag}, {31'd0, e.z});
            chk("write_latency", cyc, e.cyc);
         end
      end
   end

   task automatic wait_fetch(input int limit);
      int n = 0;
      while (instr_req !== 1'b1 && n < limit) begin
         @(posedge clk); #1;
         n++;
      end
      if (instr_req !== 1'b1) begin
         n_total++;
         $display("FAIL fetch_timeout: instr_req got 0, expected 1 after %0d cycles", limit);
      end
   endtask

   // Issue one instruction, queue its expected write, then check state on return to FETCH.
   task automatic exec(input logic [15:0] instr, input logic [7:0] d1, input logic [7:0] d2,
                       input bit wr, input logic [2:0] wreg, input logic [7:0] wdata,
                       input logic z, input logic [7:0] npc);
      exp_t e;
      wait_fetch(10);
      read_data1  = d1;
      read_data2  = d2;
      instr_data  = instr;
      instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      if (wr) begin
         e.wreg = wreg; e.wdata = wdata; e.z = z; e.cyc = cyc + 2;
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      chk("read_reg1", {29'd0, read_reg1}, {29'd0, instr[8:6]});
      chk("read_reg2", {29'd0, read_reg2}, {29'd0, instr[5:3]});
      @(posedge clk); #1;
      wait_fetch(10);
      chk("next_pc", {24'd0, pc}, {24'd0, npc});
      chk("zero_flag", {31'd0, zero_flag}, {31'd0, z});
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; instr_valid = 1'b0; instr_data = 16'h0000;
      read_data1 = 8'h00; read_data2 = 8'h00;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_pc", {24'd0, pc}, 32'h00);
      chk("rst_instr_req", {31'd0, instr_req}, 32'd1);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_zero", {31'd0, zero_flag}, 32'd0);
      chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
      chk("rst_write_reg", {29'd0, write_reg}, 32'd0);
      chk("rst_write_data", {24'd0, write_data}, 32'd0);
      chk("rst_read_reg1", {29'd0, read_reg1}, 32'd0);

      exec(16'h6CFA, 8'h00, 8'h00, 1, 3'd6, 8'hFA, 1'b0, 8'h01);   // LDI R6,0xFA
      exec(16'h1298, 8'h80, 8'h80, 1, 3'd1, 8'h00, 1'b1, 8'h02);   // ADD R1,R2,R3 wraps to 0

      for (int i = 0; i < 5; i++) begin                           // FETCH stall
         @(posedge clk); #1;
         chk("stall_instr_req", {31'd0, instr_req}, 32'd1);
         chk("stall_pc", {24'd0, pc}, 32'h02);
      end

      exec(16'h2450, 8'h05, 8'h07, 1, 3'd2, 8'hFE, 1'b0, 8'h03);   // SUB borrow discarded
      exec(16'h8040, 8'h00, 8'h00, 0, 3'd0, 8'h00, 1'b0, 8'h04);   // JZ not taken
      exec(16'h5648, 8'h3C, 8'h3C, 1, 3'd3, 8'h00, 1'b1, 8'h05);   // XOR -> Z=1
      exec(16'h8040, 8'h00, 8'h00, 0, 3'd0, 8'h00, 1'b1, 8'h40);   // JZ taken
      exec(16'h90FF, 8'h00, 8'h00, 0, 3'd0, 8'h00, 1'b1, 8'hFF);   // JMP 0xFF
      exec(16'h7940, 8'hA5, 8'h11, 1, 3'd4, 8'hA5, 1'b1, 8'h00);   // MOV at 0xFF, pc wraps, Z kept
      exec(16'h31B8, 8'hF3, 8'h3F, 1, 3'd0, 8'h33, 1'b0, 8'h01);   // AND into R0
      exec(16'hB123, 8'h00, 8'h00, 0, 3'd0, 8'h00, 1'b0, 8'h02);   // opcode B acts as NOP

      // HLT, then ignored fetch attempts, then reset out of HALT
      wait_fetch(10);
      instr_data = 16'hF000; instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      chk("halt_halted", {31'd0, halted}, 32'd1);
      chk("halt_instr_req", {31'd0, instr_req}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         instr_data = 16'h6CFA;
         instr_valid = (i % 2 == 0);
         @(posedge clk); #1;
         chk("halt_hold", {31'd0, halted}, 32'd1);
         chk("halt_pc", {24'd0, pc}, 32'h03);
      end
      instr_valid = 1'b0;
      pulse_reset();
      chk("unhalt_halted", {31'd0, halted}, 32'd0);
      chk("unhalt_pc", {24'd0, pc}, 32'h00);
      chk("unhalt_instr_req", {31'd0, instr_req}, 32'd1);

      // Reset during the WRITEBACK cycle of LDI R6,0xFA
      instr_data = 16'h6CFA; instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      chk("wb_rst_reg_write", {31'd0, reg_write}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("wb_rst_pc", {24'd0, pc}, 32'h00);
      chk("wb_rst_instr_req", {31'd0, instr_req}, 32'd1);

      exec(16'h6CFA, 8'h00, 8'h00, 1, 3'd6, 8'hFA, 1'b0, 8'h01);
      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
